snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Master sequencer for the snake game. It owns the game state consumed by the snake datapath (`M_STATE`), arbitrates the five push-buttons into a registered direction (`DIR`), and places food targets (`TARGET_H`/`TARGET_V`) from a free-running LFSR. It also counts `REACHED` events into a score, declares a win, and issues a one-cycle snake reset at each new game.

## Interface
- `SCORE_MAX`, default 10: number of targets needed to win, range 1..255.
- `SEED_H`, default 8'hA5: non-zero reset seed of the horizontal LFSR.
- `SEED_V`, default 7'h5A: non-zero reset seed of the vertical LFSR.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: reset, asynchronous, active-low.
- `BTNU`/`BTNR`/`BTND`/`BTNL` in 1 each: debounced, synchronous direction buttons, level-high.
- `BTNC` in 1: debounced start/acknowledge button, level-high.
- `REACHED` in 1: one-cycle pulse from the snake datapath when the head hits the target.
- `M_STATE` out 2: game state. 00 = IDLE, 01 = PLAY, 10 = WIN.
- `DIR` out 2: direction. 00 = up, 01 = right, 10 = down, 11 = left.
- `TARGET_H` out 8: target column, 0..159.
- `TARGET_V` out 7: target row, 0..119.
- `SCORE` out 8: targets eaten in the current game.
- `SNAKE_RST` out 1: one-cycle active-high synchronous reset for the snake datapath.

## Operation
- **Reset values.** All outputs are registered. While `RESET` is low: `M_STATE`=00, `DIR`=00, `TARGET_H`=0, `TARGET_V`=0, `SCORE`=0, `SNAKE_RST`=0, and the LFSRs are loaded with their seeds.
- **Button edges.** Each button is registered once. Edge = current level AND NOT registered level. Holding a button produces exactly one edge.
- **LFSRs.** Both advance every cycle in every state.
  - H LFSR: 8-bit, polynomial x^8+x^6+x^5+x^4+1.
  - V LFSR: 7-bit, polynomial x^7+x^6+1.
  - Both shift left; the XOR feedback enters bit 0.
  - Folding: H = lfsr_h if lfsr_h < 160, else lfsr_h − 96. V = lfsr_v if lfsr_v < 120, else lfsr_v − 64.
- **IDLE.** A `BTNC` edge moves to PLAY. On that same edge: `SCORE`←0, `DIR`←00, `SNAKE_RST`←1, and the target is loaded from the folded LFSRs. All other inputs are ignored.
- **PLAY.**
  - A direction edge loads `DIR`. If several edges occur in the same cycle, priority is U > R > D > L.
  - A `REACHED` pulse increments `SCORE` and reloads the target from the folded LFSRs on the same edge.
  - If `SCORE`+1 == `SCORE_MAX`, the state moves to WIN on that same edge, with the incremented score.
  - `BTNC` is ignored.
- **WIN.** `SCORE` and the target hold. A `BTNC` edge moves to IDLE. Direction edges and `REACHED` are ignored.
- **Illegal state 11.** Recovers to IDLE on the next edge.
- **Simultaneous events.**
  - `REACHED` together with a direction edge in PLAY: both take effect.
  - `REACHED` outside PLAY: ignored.
  - `SCORE` never wraps; `SCORE_MAX` caps it.
- **Reset mid-game.** Asynchronous return to the reset values. `SNAKE_RST` is not asserted by `RESET`; the snake's own reset is driven separately.

## Timing
- Button edge or `REACHED` sampled at edge k → output updated after edge k (1-cycle latency).
- `SNAKE_RST` is high for exactly the cycle in which `M_STATE` first reads 01. It is 0 in every other cycle.
- The target is stable between `REACHED` pulses. It changes only on the `REACHED` edge or on the game-start edge.
- No combinational path from any input to any output.

## Configuration
- `SNAKE_NO_REVERSE_EN` defined: in PLAY, a direction edge opposite to the current `DIR` (up↔down, left↔right) is discarded, and the next-lower-priority edge in the same cycle, if any, is considered instead.
- `SNAKE_NO_REVERSE_EN` undefined: every direction edge is accepted per priority.

## Structure
- Package `snake_pkg`:
  - state encodings `ST_IDLE`/`ST_PLAY`/`ST_WIN`
  - direction encodings `DIR_UP`/`DIR_RIGHT`/`DIR_DOWN`/`DIR_LEFT`
  - `MAX_X`=159, `MAX_Y`=119
- Sub-module `snake_target_lfsr`: holds both LFSRs, the seeds and the folding logic. It outputs folded H/V combinationally from its registered state.

## Test plan
- Reset, then a `BTNC` pulse → `M_STATE`=01 one cycle later. `SNAKE_RST` is high for exactly 1 cycle, `SCORE`=0, `DIR`=00, and the target equals the folded model LFSR value (H<160, V<120).
- In PLAY, `BTNR` held high for 5 cycles → `DIR`=01 after 1 cycle and no further edges. `BTNL`+`BTND` in the same cycle → `DIR`=10.
- With `SNAKE_NO_REVERSE_EN` and `DIR`=01, a `BTNL` edge → `DIR` stays 01. Without the macro → `DIR`=11.
- `SCORE_MAX`=3, three `REACHED` pulses → `SCORE` 1, 2, 3 with the target changing at each pulse, and `M_STATE`=10 on the third pulse. A further `REACHED` leaves `SCORE`=3.
- In WIN, a `BTNC` edge → IDLE, then a `BTNC` edge → PLAY with `SCORE`=0.
- Force the H LFSR to 8'hFF and the V LFSR to 7'h7F at a `REACHED` edge → `TARGET_H`=159, `TARGET_V`=63. Assert `RESET` low mid-PLAY → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings and playfield limits for the snake game controller.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_ILL  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   localparam int MAX_X = 159;
   localparam int MAX_Y = 119;

   // Up<->down and left<->right differ only in the MSB of the encoding.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/snake_target_lfsr.sv
// Free-running H/V LFSRs with folding of their values into the 160x120 playfield.
module snake_target_lfsr
   import snake_pkg::*;
#(
   parameter logic [7:0] SEED_H = 8'hA5,
   parameter logic [6:0] SEED_V = 7'h5A
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic [7:0] o_target_h,
   output logic [6:0] o_target_v
);

   logic [7:0] r_lfsr_h;
   logic [6:0] r_lfsr_v;
   logic       w_fb_h;
   logic       w_fb_v;

   // Taps: x^8+x^6+x^5+x^4+1 and x^7+x^6+1.
   assign w_fb_h = r_lfsr_h[7] ^ r_lfsr_h[5] ^ r_lfsr_h[4] ^ r_lfsr_h[3];
   assign w_fb_v = r_lfsr_v[6] ^ r_lfsr_v[5];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_lfsr_h <= SEED_H;
         r_lfsr_v <= SEED_V;
      end else begin
         r_lfsr_h <= {r_lfsr_h[6:0], w_fb_h};
         r_lfsr_v <= {r_lfsr_v[5:0], w_fb_v};
      end
   end

   assign o_target_h = (r_lfsr_h > 8'(MAX_X)) ? r_lfsr_h - 8'd96 : r_lfsr_h;
   assign o_target_v = (r_lfsr_v > 7'(MAX_Y)) ? r_lfsr_v - 7'd64 : r_lfsr_v;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: state, direction arbitration, score and food placement.
// Optional SNAKE_NO_REVERSE_EN discards direction edges that reverse the snake.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int         SCORE_MAX = 10,
   parameter logic [7:0] SEED_H    = 8'hA5,
   parameter logic [6:0] SEED_V    = 7'h5A
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTNU,
   input  logic       BTNR,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNC,
   input  logic       REACHED,
   output logic [1:0] M_STATE,
   output logic [1:0] DIR,
   output logic [7:0] TARGET_H,
   output logic [6:0] TARGET_V,
   output logic [7:0] SCORE,
   output logic       SNAKE_RST
);

   state_t     r_state;
   dir_t       r_dir;
   logic [7:0] r_tgt_h;
   logic [6:0] r_tgt_v;
   logic [7:0] r_score;
   logic       r_snake_rst;
   logic [4:0] r_btn;

   logic [4:0] w_btn;
   logic [4:0] w_edge;
   logic [7:0] w_fold_h;
   logic [6:0] w_fold_v;
   logic       w_dir_vld;
   dir_t       w_dir_new;

   snake_target_lfsr #(.SEED_H(SEED_H), .SEED_V(SEED_V)) u_lfsr (
      .CLK        (CLK),
      .RESET      (RESET),
      .o_target_h (w_fold_h),
      .o_target_v (w_fold_v)
   );

   // Bit index of each direction button equals its DIR encoding.
   assign w_btn  = {BTNC, BTNL, BTND, BTNR, BTNU};
   assign w_edge = w_btn & ~r_btn;

   // Scan lowest priority first so the highest-priority accepted edge wins.
   always_comb begin
      w_dir_vld = 1'b0;
      w_dir_new = r_dir;
      for (int i = 3; i >= 0; i--) begin
`ifdef SNAKE_NO_REVERSE_EN
         if (w_edge[i] && (dir_t'(2'(i)) != opposite(r_dir))) begin
`else
         if (w_edge[i]) begin
`endif
            w_dir_vld = 1'b1;
            w_dir_new = dir_t'(2'(i));
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= ST_IDLE;
         r_dir       <= DIR_UP;
         r_tgt_h     <= '0;
         r_tgt_v     <= '0;
         r_score     <= '0;
         r_snake_rst <= 1'b0;
         r_btn       <= '0;
      end else begin
         r_btn       <= w_btn;
         r_snake_rst <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_edge[4]) begin
                  r_state     <= ST_PLAY;
                  r_score     <= '0;
                  r_dir       <= DIR_UP;
                  r_snake_rst <= 1'b1;
                  r_tgt_h     <= w_fold_h;
                  r_tgt_v     <= w_fold_v;
               end
            end
            ST_PLAY: begin
               if (w_dir_vld) r_dir <= w_dir_new;
               if (REACHED) begin
                  r_score <= r_score + 8'd1;
                  r_tgt_h <= w_fold_h;
                  r_tgt_v <= w_fold_v;
                  if (r_score + 8'd1 == 8'(SCORE_MAX)) r_state <= ST_WIN;
               end
            end
            ST_WIN: begin
               if (w_edge[4]) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign M_STATE   = r_state;
   assign DIR       = r_dir;
   assign TARGET_H  = r_tgt_h;
   assign TARGET_V  = r_tgt_v;
   assign SCORE     = r_score;
   assign SNAKE_RST = r_snake_rst;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: cycle model plus directed scenarios with literal checks.
module tb_snake_game_ctrl;

   localparam int SMAX = 3;
`ifdef SNAKE_NO_REVERSE_EN
   localparam bit NOREV = 1'b1;
`else
   localparam bit NOREV = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic BTNU = 0, BTNR = 0, BTND = 0, BTNL = 0, BTNC = 0, REACHED = 0;
   logic [1:0] M_STATE, DIR;
   logic [7:0] TARGET_H, SCORE;
   logic [6:0] TARGET_V;
   logic       SNAKE_RST;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   snake_game_ctrl #(.SCORE_MAX(SMAX), .SEED_H(8'hA5), .SEED_V(7'h5A)) dut (
      .CLK(CLK), .RESET(RESET), .BTNU(BTNU), .BTNR(BTNR), .BTND(BTND), .BTNL(BTNL),
      .BTNC(BTNC), .REACHED(REACHED), .M_STATE(M_STATE), .DIR(DIR),
      .TARGET_H(TARGET_H), .TARGET_V(TARGET_V), .SCORE(SCORE), .SNAKE_RST(SNAKE_RST)
   );

   task automatic cmp(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_state;   // 0 idle, 1 play, 2 win
   int         m_dir, m_score, m_th, m_tv;
   bit         m_srst;
   logic [7:0] m_lh;
   logic [6:0] m_lv;
   logic [4:0] m_prev, mb, me;
   bit         taken;

   function automatic int fold_h(input logic [7:0] v);
      return (int'(v) < 160) ? int'(v) : int'(v) - 96;
   endfunction
   function automatic int fold_v(input logic [6:0] v);
      return (int'(v) < 120) ? int'(v) : int'(v) - 64;
   endfunction

   task automatic model_reset();
      m_state = 0; m_dir = 0; m_score = 0; m_th = 0; m_tv = 0; m_srst = 0;
      m_lh = 8'hA5; m_lv = 7'h5A; m_prev = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge RESET);
         if (!RESET) model_reset();
         else begin
            mb = {BTNC, BTNL, BTND, BTNR, BTNU};
            me = mb & ~m_prev;
            m_prev = mb;
            m_srst = 0;
            if (m_state == 0) begin
               if (me[4]) begin
                  m_state = 1; m_score = 0; m_dir = 0; m_srst = 1;
                  m_th = fold_h(m_lh); m_tv = fold_v(m_lv);
               end
            end else if (m_state == 1) begin
               taken = 0;
               for (int k = 0; k < 4; k++)
                  if (me[k] && !taken && !(NOREV && ((k ^ 2) == m_dir))) begin
                     m_dir = k; taken = 1;
                  end
               if (REACHED) begin
                  m_score++;
                  m_th = fold_h(m_lh); m_tv = fold_v(m_lv);
                  if (m_score == SMAX) m_state = 2;
               end
            end else begin
               if (me[4]) m_state = 0;
            end
            // polynomial taps expressed as masks: exponent e -> bit e-1
            m_lh = {m_lh[6:0], ^(m_lh & 8'hB8)};
            m_lv = {m_lv[5:0], ^(m_lv & 7'h60)};
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge CLK);
         if (RESET === 1'b1) begin
            cmp("m_state",   int'(M_STATE),   m_state);
            cmp("m_dir",     int'(DIR),       m_dir);
            cmp("m_score",   int'(SCORE),     m_score);
            cmp("m_tgt_h",   int'(TARGET_H),  m_th);
            cmp("m_tgt_v",   int'(TARGET_V),  m_tv);
            cmp("m_snkrst",  int'(SNAKE_RST), int'(m_srst));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      cmp({tag, "_state"}, int'(M_STATE), 0);
      cmp({tag, "_dir"},   int'(DIR), 0);
      cmp({tag, "_th"},    int'(TARGET_H), 0);
      cmp({tag, "_tv"},    int'(TARGET_V), 0);
      cmp({tag, "_score"}, int'(SCORE), 0);
      cmp({tag, "_srst"},  int'(SNAKE_RST), 0);
   endtask

   initial begin
      int n;
      #23;
      check_reset_vals("rst");
      @(negedge CLK); #1;
      RESET = 1'b1;
      tick(); tick();

      // game start
      BTNC = 1; tick(); BTNC = 0;
      cmp("start_state", int'(M_STATE), 1);
      cmp("start_srst",  int'(SNAKE_RST), 1);
      cmp("start_score", int'(SCORE), 0);
      cmp("start_dir",   int'(DIR), 0);
      cmp("start_h_rng", int'(TARGET_H < 8'd160), 1);
      cmp("start_v_rng", int'(TARGET_V < 7'd120), 1);
      tick();
      cmp("srst_once", int'(SNAKE_RST), 0);

      // held button gives one edge
      BTNR = 1; tick();
      cmp("hold_r_dir", int'(DIR), 1);
      repeat (4) tick();
      BTNR = 0;
      cmp("hold_r_dir2", int'(DIR), 1);

      // simultaneous L+D: down has priority
      BTNL = 1; BTND = 1; tick(); BTNL = 0; BTND = 0;
      cmp("ld_dir", int'(DIR), 2);
      BTNR = 1; tick(); BTNR = 0;
      cmp("r_dir", int'(DIR), 1);
      BTNL = 1; tick(); BTNL = 0;
      cmp("rev_dir", int'(DIR), NOREV ? 1 : 3);

      // REACHED exactly when the H LFSR holds 8'hFF
      n = 0;
      while (m_lh != 8'hFF && n < 300) begin tick(); n++; end
      cmp("wait_h_ff", int'(n < 300), 1);
      REACHED = 1; tick(); REACHED = 0;
      cmp("fold_h_ff", int'(TARGET_H), 159);
      cmp("score1", int'(SCORE), 1);

      // REACHED exactly when the V LFSR holds 7'h7F
      n = 0;
      while (m_lv != 7'h7F && n < 300) begin tick(); n++; end
      cmp("wait_v_7f", int'(n < 300), 1);
      REACHED = 1; BTNU = 1; tick(); REACHED = 0; BTNU = 0;
      cmp("fold_v_7f", int'(TARGET_V), 63);
      cmp("score2", int'(SCORE), 2);
      cmp("reach_dir_u", int'(DIR), NOREV ? 0 : 0);

      // third target wins; further REACHED ignored
      REACHED = 1; tick(); REACHED = 0;
      cmp("score3", int'(SCORE), 3);
      cmp("win_state", int'(M_STATE), 2);
      REACHED = 1; BTNL = 1; tick(); REACHED = 0; BTNL = 0;
      cmp("win_score_hold", int'(SCORE), 3);

      // WIN -> IDLE -> PLAY
      BTNC = 1; tick(); BTNC = 0;
      cmp("win_to_idle", int'(M_STATE), 0);
      tick();
      REACHED = 1; tick(); REACHED = 0;
      cmp("idle_reach_ign", int'(SCORE), 3);
      BTNC = 1; tick(); BTNC = 0;
      cmp("restart_state", int'(M_STATE), 1);
      cmp("restart_score", int'(SCORE), 0);
      REACHED = 1; BTNR = 1; tick(); REACHED = 0; BTNR = 0;
      cmp("mid_score", int'(SCORE), 1);

      // asynchronous reset between clock edges
      #2;
      RESET = 1'b0;
      #1;
      check_reset_vals("async");
      @(negedge CLK); #1;
      RESET = 1'b1;
      tick(); tick();
      cmp("post_rst_idle", int'(M_STATE), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
